// File: rtl/comma_pkg.sv
// Shared constants, state encoding and helpers for the comma aligner and the
// downstream 8b/10b decoder checks.
package comma_pkg;

  localparam int SYM_W = 10;

  localparam logic [SYM_W-1:0] COMMA_N = 10'b0011111010;
  localparam logic [SYM_W-1:0] COMMA_P = 10'b1100000101;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_e;

  function automatic logic [3:0] popcount10(input logic [SYM_W-1:0] v);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < SYM_W; i++) begin
      cnt = cnt + {3'd0, v[i]};
    end
    return cnt;
  endfunction

  // Saturating 3-bit increment so run-length counters never wrap back to zero.
  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    return (v == 3'd7) ? 3'd7 : v + 3'd1;
  endfunction

endpackage

// File: rtl/comma_aligner_if.sv
// Serial-in / aligned-symbol-out bundle between the line receiver and the
// comma aligner.
interface comma_aligner_if;
  import comma_pkg::*;

  logic             enable_i;
  logic             bit_i;
  logic [SYM_W-1:0] data_o;
  logic             valid_o;
  logic             comma_o;
  logic             code_err_o;
  logic             locked_o;

  modport master (
    output enable_i, bit_i,
    input  data_o, valid_o, comma_o, code_err_o, locked_o
  );

  modport slave (
    input  enable_i, bit_i,
    output data_o, valid_o, comma_o, code_err_o, locked_o
  );

endinterface

// File: rtl/sym_weight_check.sv
// Classifies a 10-bit window as a K28.5 comma and/or an illegal code weight.
module sym_weight_check
  import comma_pkg::*;
(
  input  logic [SYM_W-1:0] win,
  output logic             is_comma,
  output logic             bad_wt
);

  logic [3:0] wt_s;

  // Legal 8b/10b code groups carry four, five or six ones.
  always_comb begin
    wt_s     = popcount10(win);
    is_comma = (win == COMMA_N) || (win == COMMA_P);
    bad_wt   = (wt_s < 4'd4) || (wt_s > 4'd6);
  end

endmodule

// File: rtl/comma_aligner.sv
// Bit-serial K28.5 hunter: finds symbol boundaries, acquires lock after
// repeated aligned commas and drops it on sustained code-weight errors.
module comma_aligner
  import comma_pkg::*;
#(
  parameter int LOCK_COMMAS = 3,
  parameter int ERR_LIMIT   = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  comma_aligner_if.slave   bus
);

  localparam logic [2:0] LOCK_TH = 3'(LOCK_COMMAS);
  localparam logic [2:0] ERR_TH  = 3'(ERR_LIMIT);

  state_e           state_r, state_nxt_s;
  logic [SYM_W-2:0] sr_r;
  logic [3:0]       phase_r, phase_nxt_s;
  logic [2:0]       comma_cnt_r, comma_cnt_nxt_s;
  logic [2:0]       err_cnt_r, err_cnt_nxt_s;
  logic [SYM_W-1:0] data_r, data_nxt_s;
  logic             valid_r, valid_nxt_s;
  logic             comma_r, comma_nxt_s;
  logic             code_err_r, code_err_nxt_s;
  logic             locked_r;

  logic [SYM_W-1:0] win_s;
  logic             is_comma_s, bad_wt_s, boundary_s;
  logic [2:0]       cnt_inc_s, err_inc_s;
  logic             lock_hit_s, err_evt_s, err_hit_s;

  assign win_s      = {sr_r, bus.bit_i};
  assign boundary_s = bus.enable_i && (phase_r == 4'd9);
  assign cnt_inc_s  = sat_inc3(comma_cnt_r);
  assign err_inc_s  = sat_inc3(err_cnt_r);
  assign lock_hit_s = boundary_s && is_comma_s && (cnt_inc_s >= LOCK_TH);
  // A bad boundary symbol and a misaligned comma on one edge count as one error.
  assign err_evt_s  = bus.enable_i && ((boundary_s && bad_wt_s) || (is_comma_s && !boundary_s));
  assign err_hit_s  = err_evt_s && (err_inc_s >= ERR_TH);

  sym_weight_check u_wt (
    .win      (win_s),
    .is_comma (is_comma_s),
    .bad_wt   (bad_wt_s)
  );

  // State register; reset discards any partial symbol and all progress.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= HUNT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state selection.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      HUNT: begin
        if (bus.enable_i && is_comma_s) state_nxt_s = CHECK;
        else                            state_nxt_s = HUNT;
      end
      CHECK: begin
        if (lock_hit_s)                                 state_nxt_s = LOCKED;
        else if (boundary_s && !is_comma_s && bad_wt_s) state_nxt_s = HUNT;
        else                                            state_nxt_s = CHECK;
      end
      LOCKED: begin
        if (err_hit_s) state_nxt_s = HUNT;
        else           state_nxt_s = LOCKED;
      end
      default: state_nxt_s = HUNT;
    endcase
  end

  // Phase, counters and symbol emission for the current edge.
  always_comb begin
    phase_nxt_s     = phase_r;
    comma_cnt_nxt_s = comma_cnt_r;
    err_cnt_nxt_s   = err_cnt_r;
    data_nxt_s      = data_r;
    valid_nxt_s     = 1'b0;
    comma_nxt_s     = 1'b0;
    code_err_nxt_s  = 1'b0;
    if (bus.enable_i) begin
      phase_nxt_s = boundary_s ? 4'd0 : phase_r + 4'd1;
      case (state_r)
        HUNT: begin
          if (is_comma_s) begin
            phase_nxt_s     = 4'd0;
            comma_cnt_nxt_s = 3'd1;
          end else begin
            comma_cnt_nxt_s = comma_cnt_r;
          end
        end
        CHECK: begin
          if (is_comma_s && !boundary_s) begin
            phase_nxt_s     = 4'd0;
            comma_cnt_nxt_s = 3'd1;
          end else if (boundary_s && is_comma_s) begin
            comma_cnt_nxt_s = cnt_inc_s;
            if (lock_hit_s) begin
              data_nxt_s     = win_s;
              valid_nxt_s    = 1'b1;
              comma_nxt_s    = 1'b1;
              code_err_nxt_s = bad_wt_s;
              err_cnt_nxt_s  = 3'd0;
            end else begin
              err_cnt_nxt_s = err_cnt_r;
            end
          end else if (boundary_s && bad_wt_s) begin
            comma_cnt_nxt_s = 3'd0;
          end else begin
            comma_cnt_nxt_s = comma_cnt_r;
          end
        end
        LOCKED: begin
          if (boundary_s) begin
            data_nxt_s     = win_s;
            valid_nxt_s    = 1'b1;
            comma_nxt_s    = is_comma_s;
            code_err_nxt_s = bad_wt_s;
          end else begin
            data_nxt_s = data_r;
          end
          if (err_hit_s) begin
            err_cnt_nxt_s   = 3'd0;
            comma_cnt_nxt_s = 3'd0;
          end else if (err_evt_s) begin
            err_cnt_nxt_s = err_inc_s;
          end else if (boundary_s) begin
            err_cnt_nxt_s = 3'd0;
          end else begin
            err_cnt_nxt_s = err_cnt_r;
          end
        end
        default: begin
          phase_nxt_s     = 4'd0;
          comma_cnt_nxt_s = 3'd0;
          err_cnt_nxt_s   = 3'd0;
        end
      endcase
    end else begin
      phase_nxt_s = phase_r;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_r        <= '0;
      phase_r     <= 4'd0;
      comma_cnt_r <= 3'd0;
      err_cnt_r   <= 3'd0;
      data_r      <= '0;
      valid_r     <= 1'b0;
      comma_r     <= 1'b0;
      code_err_r  <= 1'b0;
      locked_r    <= 1'b0;
    end else begin
      if (bus.enable_i) sr_r <= win_s[SYM_W-2:0];
      phase_r     <= phase_nxt_s;
      comma_cnt_r <= comma_cnt_nxt_s;
      err_cnt_r   <= err_cnt_nxt_s;
      data_r      <= data_nxt_s;
      valid_r     <= valid_nxt_s;
      comma_r     <= comma_nxt_s;
      code_err_r  <= code_err_nxt_s;
      locked_r    <= (state_nxt_s == LOCKED);
    end
  end

  assign bus.data_o     = data_r;
  assign bus.valid_o    = valid_r;
  assign bus.comma_o    = comma_r;
  assign bus.code_err_o = code_err_r;
  assign bus.locked_o   = locked_r;

endmodule

// File: doc/comma_aligner.md
Name: comma_aligner

Overview:
Serial-to-parallel front end that sits directly upstream of the 8b/10b decoder. It shifts in one line bit per enabled clock and hunts for the K28.5 comma to find symbol boundaries. It then emits aligned 10-bit code groups with a one-cycle valid strobe. Lock is acquired after repeated aligned commas and is dropped on sustained code-weight errors.

Parameters:
LOCK_COMMAS, 3, consecutive boundary-aligned commas needed to go from CHECK to LOCKED (range 1..7)
ERR_LIMIT, 4, consecutive bad symbols or misaligned commas in LOCKED that force HUNT (range 1..7)
COMMA_N, 10'b0011111010, K28.5 RD- pattern, abcdei_fghj, a = MSB
COMMA_P, 10'b1100000101, K28.5 RD+ pattern

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_i  input  1  synchronous, active-high reset; overrides enable_i
enable_i  input  1  bit_i sampled and state advanced only when high
bit_i  input  1  serial line bit; bit a of each symbol arrives first
data_o  output  10  aligned code group, a = data_o[9], j = data_o[0]
valid_o  output  1  one-cycle pulse when data_o holds a new symbol
comma_o  output  1  qualifies valid_o: symbol equals COMMA_N or COMMA_P
code_err_o  output  1  qualifies valid_o: symbol weight (count of ones) not in {4,5,6}
locked_o  output  1  high while the FSM is in LOCKED

Behaviour:
- Reset (rst_i=1 at an edge): sr=0, phase=0, comma_cnt=0, err_cnt=0, state=HUNT. data_o, valid_o, comma_o, code_err_o and locked_o are all 0.
- Window: win = {sr[8:0], bit_i}, combinational. On each enabled edge, sr <= win.
- is_comma: win==COMMA_N or win==COMMA_P. bad_wt: popcount(win) is not 4, 5 or 6.
- Boundary: an enabled edge with phase==9. phase counts 0..9 and wraps to 0.
- enable_i=0: sr, phase, counters and state hold. valid_o, comma_o and code_err_o are 0.
- Latency: data_o and valid_o update on the same edge that samples bit j. The strobe is visible in the following cycle.
- valid_o is asserted only for symbols taken in LOCKED, including the edge that enters LOCKED. Otherwise valid_o stays 0 and data_o holds its last value.
- HUNT:
  - is_comma at any phase: phase<=0, comma_cnt<=1, go to CHECK.
  - Otherwise phase advances.
- CHECK:
  - is_comma at a non-boundary edge: realign with phase<=0, comma_cnt<=1; stay in CHECK.
  - Boundary and is_comma: comma_cnt+1. If it reaches LOCK_COMMAS, go to LOCKED, emit the symbol (valid_o=1, comma_o=1), and err_cnt<=0.
  - Boundary, no comma and bad_wt: go to HUNT, comma_cnt<=0.
  - Boundary, no comma, good weight: no change.
- LOCKED:
  - Every boundary: data_o<=win, valid_o=1, comma_o=is_comma, code_err_o=bad_wt.
  - bad_wt at a boundary: err_cnt+1. A good symbol at a boundary clears err_cnt.
  - is_comma at a non-boundary edge: err_cnt+1, no realign.
  - If bad_wt at a boundary and a misaligned comma occur on the same edge, count one error.
  - err_cnt reaching ERR_LIMIT: go to HUNT on that edge. The offending symbol is still emitted with code_err_o=1. locked_o is 0 from the next cycle. Counters clear.
- Saturation: counters are 3 bits and never wrap.
- Reset mid-symbol or while locked: everything returns to reset values at that edge. The partial symbol is discarded.

Decomposition:
- Package comma_pkg:
  - K28.5 constants COMMA_N and COMMA_P
  - 2-bit state encoding HUNT=0, CHECK=1, LOCKED=2
  - SYM_W=10
  - popcount10 function
- Combinational sub-module sym_weight_check: input 10-bit win, outputs is_comma and bad_wt. It is reusable by the decoder's pop_h/pop_l checks.
- The FSM, shift register and counters stay in comma_aligner.

Test Plan:
- Reset, then 2 garbage bits (1,0), then 3x COMMA_N serially -> locked_o rises after bit j of the 3rd comma. On that pulse data_o=0011111010, valid_o=1, comma_o=1, code_err_o=0.
- Locked, then 5x D21.5 (1010101010) -> exactly one valid_o per 10 enabled cycles, data_o=1010101010, comma_o=0, code_err_o=0.
- Locked, then 3x 0000000001, 1x 1010101010, then 4x 0000000001:
  - code_err_o=1 on each bad symbol.
  - The good symbol clears err_cnt, so lock is held.
  - locked_o drops after the 4th consecutive bad symbol.
- Locked, enable_i=0 for 7 cycles mid-symbol (toggling bit_i) -> no valid_o. After re-enable, the next symbol is 1010101010 with unchanged alignment.
- In CHECK after 1 comma:
  - A COMMA_P offset by 3 bits -> realign with comma_cnt=1; lock is reached only after 2 more aligned commas.
  - Separately, boundary symbol 1111111111 -> back to HUNT.
- rst_i=1 for one edge while locked mid-symbol -> next cycle all outputs are 0 and state is HUNT. Relock needs 3 fresh commas.
